// File: rtl/retro_hyperram_burst_splitter_if.sv
// Request/command bus of the HyperRAM burst splitter.
// slave = splitter side, master = requester/controller side.
interface retro_hyperram_burst_splitter_if #(
  parameter int AddressBusWidth = 23,
  parameter int LengthWidth     = 16,
  parameter int BoundaryBits    = 9
);
  logic                       ReqValid;
  logic                       ReqReady;
  logic                       ReqRead;
  logic [AddressBusWidth-1:0] ReqAddress;
  logic [LengthWidth-1:0]     ReqLength;
  logic                       CmdValid;
  logic                       CmdReady;
  logic                       CmdRead;
  logic [AddressBusWidth-1:0] CmdAddress;
  logic [BoundaryBits:0]      CmdLength;
  logic                       Done;
  logic                       Overflow;
  logic                       Busy;

  modport slave (
    input  ReqValid, ReqRead, ReqAddress, ReqLength, CmdReady,
    output ReqReady, CmdValid, CmdRead, CmdAddress, CmdLength, Done, Overflow, Busy
  );
  modport master (
    output ReqValid, ReqRead, ReqAddress, ReqLength, CmdReady,
    input  ReqReady, CmdValid, CmdRead, CmdAddress, CmdLength, Done, Overflow, Busy
  );
endinterface

// File: rtl/retro_hyperram_burst_splitter.sv
// Splits linear word requests into controller commands that never cross a 2^BoundaryBits-word block.
// Optional HYPERRAM_TOP_CLAMP_EN: stop at the top word and flag Overflow instead of wrapping to 0.
module retro_hyperram_burst_splitter #(
  parameter int AddressBusWidth = 23,
  parameter int LengthWidth     = 16,
  parameter int BoundaryBits    = 9
) (
  input  logic Clk,
  input  logic ResetN,
  retro_hyperram_burst_splitter_if.slave bus
);
  localparam int AW = AddressBusWidth;
  localparam int LW = LengthWidth;
  localparam int BB = BoundaryBits;
  localparam int CW = (LW > BB + 1) ? LW : BB + 1;
`ifdef HYPERRAM_TOP_CLAMP_EN
  localparam bit TopClamp = 1'b1;
`else
  localparam bit TopClamp = 1'b0;
`endif

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t         state;
  logic           req_ready, cmd_valid, done_q, ovf_q, busy_q, rd_q, top_q;
  logic [AW-1:0]  addr_q;
  logic [BB:0]    len_q;
  logic [LW-1:0]  rem_q;   // words still to issue after the command currently presented

  logic [AW-1:0]  src_addr;
  logic [LW-1:0]  src_rem, ch_rem;
  logic [BB:0]    room, ch_len;
  logic [AW:0]    ch_end;
  logic           ch_top;

  // One chunk calculator serves both the first command (from the request) and every follow-on.
  // The top of memory is block-aligned, so the block limit already implies the top-of-memory limit.
  always_comb begin
    src_addr = (state == IDLE) ? bus.ReqAddress : addr_q + AW'(len_q);
    src_rem  = (state == IDLE) ? bus.ReqLength  : rem_q;
    room     = (BB+1)'(1 << BB) - {1'b0, src_addr[BB-1:0]};
    ch_len   = (CW'(src_rem) < CW'(room)) ? (BB+1)'(src_rem) : room;
    ch_rem   = src_rem - LW'(ch_len);
    ch_end   = {1'b0, src_addr} + (AW+1)'(ch_len);
    ch_top   = ch_end[AW];
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state     <= IDLE;
      req_ready <= 1'b0;
      cmd_valid <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
      rd_q      <= 1'b0;
      top_q     <= 1'b0;
      addr_q    <= '0;
      len_q     <= '0;
      rem_q     <= '0;
    end else begin
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (bus.ReqValid && req_ready) begin
            rd_q <= bus.ReqRead;
            if (bus.ReqLength == '0) begin
              done_q <= 1'b1;
            end else begin
              state     <= ISSUE;
              req_ready <= 1'b0;
              cmd_valid <= 1'b1;
              busy_q    <= 1'b1;
              addr_q    <= bus.ReqAddress;
              len_q     <= ch_len;
              rem_q     <= ch_rem;
              top_q     <= ch_top;
            end
          end
        end
        ISSUE: begin
          if (bus.CmdReady) begin
            if (rem_q == '0 || (TopClamp && top_q)) begin
              state     <= IDLE;
              req_ready <= 1'b1;
              cmd_valid <= 1'b0;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
              ovf_q     <= TopClamp && top_q && (rem_q != '0);
            end else begin
              addr_q <= src_addr;
              len_q  <= ch_len;
              rem_q  <= ch_rem;
              top_q  <= ch_top;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ReqReady   = req_ready;
  assign bus.CmdValid   = cmd_valid;
  assign bus.CmdRead    = rd_q;
  assign bus.CmdAddress = addr_q;
  assign bus.CmdLength  = len_q;
  assign bus.Done       = done_q;
  assign bus.Overflow   = ovf_q;
  assign bus.Busy       = busy_q;
endmodule

// File: tb/tb_retro_hyperram_burst_splitter.sv
// Directed bench for the burst splitter; commands are checked against a scoreboard queue.
module tb_retro_hyperram_burst_splitter;
  localparam int AW = 23;
  localparam int LW = 16;
  localparam int BB = 9;

  typedef struct packed {
    logic          rd;
    logic [AW-1:0] addr;
    logic [BB:0]   len;
  } cmd_t;

  logic Clk = 1'b0;
  logic ResetN = 1'b0;
  int   errors = 0;
  int   checks = 0;
  cmd_t sb[$];

  always #5 Clk = ~Clk;

  retro_hyperram_burst_splitter_if #(.AddressBusWidth(AW), .LengthWidth(LW), .BoundaryBits(BB)) bus ();

  retro_hyperram_burst_splitter #(.AddressBusWidth(AW), .LengthWidth(LW), .BoundaryBits(BB)) dut (
    .Clk(Clk), .ResetN(ResetN), .bus(bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic push(input logic rd, input logic [AW-1:0] addr, input logic [BB:0] len);
    cmd_t c;
    c.rd = rd; c.addr = addr; c.len = len;
    sb.push_back(c);
  endtask

  task automatic request(input logic rd, input logic [AW-1:0] addr, input logic [LW-1:0] len);
    bus.ReqValid = 1'b1; bus.ReqRead = rd; bus.ReqAddress = addr; bus.ReqLength = len;
    tick();
    bus.ReqValid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input logic exp_ovf);
    bit seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (bus.Done) seen = 1;
      else tick();
    end
    chk({tag, "_done"}, 32'(seen), 32'd1);
    chk({tag, "_ovf"}, 32'(bus.Overflow), 32'(exp_ovf));
    chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
    tick();
    chk({tag, "_ready"}, 32'(bus.ReqReady), 32'd1);
    chk({tag, "_done_pulse"}, 32'(bus.Done), 32'd0);
  endtask

  // A handshake is due at the next edge whenever valid and ready are both high mid-cycle.
  always @(negedge Clk) begin
    if (ResetN && bus.CmdValid && bus.CmdReady) begin
      if (sb.size() == 0) begin
        chk("unexpected_cmd", {9'd0, bus.CmdAddress}, 32'hFFFFFFFF);
      end else begin
        cmd_t e;
        e = sb.pop_front();
        chk("cmd_rd", 32'(bus.CmdRead), 32'(e.rd));
        chk("cmd_addr", 32'(bus.CmdAddress), 32'(e.addr));
        chk("cmd_len", 32'(bus.CmdLength), 32'(e.len));
      end
    end
  end

  initial begin
    cmd_t held;
    bus.ReqValid = 1'b0; bus.ReqRead = 1'b0; bus.ReqAddress = '0; bus.ReqLength = '0;
    bus.CmdReady = 1'b1;

    // Reset values
    #12;
    chk("rst_ready", 32'(bus.ReqReady), 32'd0);
    chk("rst_valid", 32'(bus.CmdValid), 32'd0);
    chk("rst_busy", 32'(bus.Busy), 32'd0);
    chk("rst_done", 32'(bus.Done), 32'd0);
    chk("rst_ovf", 32'(bus.Overflow), 32'd0);
    chk("rst_cmd", {8'd0, bus.CmdRead, bus.CmdAddress}, 32'd0);
    chk("rst_len", 32'(bus.CmdLength), 32'd0);
    tick();
    ResetN = 1'b1;
    chk("ready_before_edge", 32'(bus.ReqReady), 32'd0);
    tick();
    chk("ready_after_edge", 32'(bus.ReqReady), 32'd1);

    // Split across a block boundary
    push(1'b1, 23'h000100, 10'h100);
    push(1'b1, 23'h000200, 10'h200);
    request(1'b1, 23'h000100, 16'h0300);
    chk("split_latency", 32'(bus.CmdValid), 32'd1);
    chk("split_busy", 32'(bus.Busy), 32'd1);
    chk("split_no_ready", 32'(bus.ReqReady), 32'd0);
    wait_done("split", 1'b0);

    // Aligned full block
    push(1'b0, 23'h000200, 10'h200);
    request(1'b0, 23'h000200, 16'h0200);
    chk("full_len_msb", 32'(bus.CmdLength[BB]), 32'd1);
    wait_done("full", 1'b0);

    // Zero length
    request(1'b1, 23'h000123, 16'h0000);
    chk("zero_done", 32'(bus.Done), 32'd1);
    chk("zero_valid", 32'(bus.CmdValid), 32'd0);
    chk("zero_ready", 32'(bus.ReqReady), 32'd1);
    tick();
    chk("zero_done_pulse", 32'(bus.Done), 32'd0);
    chk("zero_valid2", 32'(bus.CmdValid), 32'd0);

    // Backpressure on the second chunk
    push(1'b1, 23'h0000F0, 10'h110);
    push(1'b1, 23'h000200, 10'h200);
    push(1'b1, 23'h000400, 10'h0F0);
    request(1'b1, 23'h0000F0, 16'h0400);
    tick();
    bus.CmdReady = 1'b0;
    held.rd = bus.CmdRead; held.addr = bus.CmdAddress; held.len = bus.CmdLength;
    chk("bp_second_addr", 32'(held.addr), 32'h200);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold", {bus.CmdRead, bus.CmdAddress, 8'(bus.CmdLength)},
          {held.rd, held.addr, 8'(held.len)});
      chk("bp_hold_len", 32'(bus.CmdLength), 32'(held.len));
      chk("bp_valid", 32'(bus.CmdValid), 32'd1);
    end
    bus.CmdReady = 1'b1;
    wait_done("bp", 1'b0);

    // Top of memory
`ifdef HYPERRAM_TOP_CLAMP_EN
    push(1'b0, 23'h7FFF00, 10'h100);
    request(1'b0, 23'h7FFF00, 16'h0200);
    wait_done("top", 1'b1);
`else
    push(1'b0, 23'h7FFF00, 10'h100);
    push(1'b0, 23'h000000, 10'h100);
    request(1'b0, 23'h7FFF00, 16'h0200);
    wait_done("top", 1'b0);
`endif

    // Reset mid-request: asynchronous drop, no Done
    bus.CmdReady = 1'b0;
    request(1'b1, 23'h000100, 16'h0300);
    chk("mid_valid", 32'(bus.CmdValid), 32'd1);
    #2;
    ResetN = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.CmdValid), 32'd0);
    chk("mid_rst_busy", 32'(bus.Busy), 32'd0);
    chk("mid_rst_ready", 32'(bus.ReqReady), 32'd0);
    tick();
    chk("mid_rst_done", 32'(bus.Done), 32'd0);
    ResetN = 1'b1;
    bus.CmdReady = 1'b1;
    tick();
    chk("post_rst_ready", 32'(bus.ReqReady), 32'd1);
    chk("post_rst_done", 32'(bus.Done), 32'd0);
    push(1'b1, 23'h0001F8, 10'h008);
    push(1'b1, 23'h000200, 10'h008);
    request(1'b1, 23'h0001F8, 16'h0010);
    wait_done("post_rst", 1'b0);

    chk("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
